seq_divider_32b: RTL

Multi-cycle signed integer divider for the Mini SRC datapath, sitting beside the ALU and feeding the same 64-bit Z path: high word = remainder (HI), low word = quotient (LO). It takes the ALU's x/y operands on a `start` pulse and runs one restoring-division step per clock. It reports completion with a `done` pulse, so the control unit can replace the combinational `/` in the ALU's DIV slot.

---
 rtl/seq_divider_32b.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_divider_32b.sv
//------------------------------------------------------------------------------
// seq_divider_32b : multi-cycle signed restoring divider, Z = {remainder, quotient}
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider_32b #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] Z
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH:0]     r_r;
  logic               r_sq;
  logic               r_sd;
  logic               r_yz;
  logic               r_dz;
  logic [2*WIDTH-1:0] r_z;

  logic               w_accept;
  logic [WIDTH-1:0]   w_xabs;
  logic [WIDTH-1:0]   w_yabs;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_dext;
  logic               w_ge;
  logic [WIDTH-1:0]   w_qneg;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Magnitudes are kept unsigned so |-2^WIDTH-1| stays exact
    w_xabs   = x[WIDTH-1] ? -x : x;
    w_yabs   = y[WIDTH-1] ? -y : y;
    w_shift  = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    w_dext   = {1'b0, r_d};
    w_ge     = (w_shift >= w_dext);
    w_qneg   = -r_q;
    w_quot   = r_sd ? w_qneg : r_q;
    w_rem    = r_sq ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_sq    <= 1'b0;
      r_sd    <= 1'b0;
      r_yz    <= 1'b0;
      r_dz    <= 1'b0;
      r_z     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_sq    <= x[WIDTH-1];
            r_sd    <= x[WIDTH-1] ^ y[WIDTH-1];
            r_q     <= w_xabs;
            r_d     <= w_yabs;
            r_r     <= '0;
            r_yz    <= (y == '0);
            r_dz    <= 1'b0;
            r_count <= '0;
            r_state <= (y == '0) ? S_FIX : S_ITER;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ITER: begin
          if (w_ge) begin
            r_r <= w_shift - w_dext;
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= w_shift;
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_count <= r_count + 1'b1;
          if (r_count == c_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          // On a zero divisor Q still holds |x|, so re-applying the sign recovers raw x
          if (r_yz) begin
            r_z  <= {(r_sq ? w_qneg : r_q), {WIDTH{1'b1}}};
            r_dz <= 1'b1;
          end else begin
            r_z  <= {w_rem, w_quot};
          end
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_ITER) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_dz;
  assign Z           = r_z;

endmodule

`default_nettype wire
